// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Registered ALU with valid/ready handshakes, SUB, iterative
//             shift-add MUL and zero/overflow/error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic             CI,
   input  logic [2:0]       A,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] Cout,
   output logic             CO,
   output logic             OV,
   output logic             ZF,
   output logic             ERR,
   output logic             OUT_VALID,
   input  logic             OUT_READY
);

   localparam int       CW     = $clog2(WIDTH + 1);
   localparam bit [2:0] OP_XOR = 3'b000;
   localparam bit [2:0] OP_ADD = 3'b001;
   localparam bit [2:0] OP_AND = 3'b010;
   localparam bit [2:0] OP_OR  = 3'b011;
   localparam bit [2:0] OP_NOT = 3'b100;
   localparam bit [2:0] OP_SUB = 3'b101;
   localparam bit [2:0] OP_MUL = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
   logic [WIDTH-1:0]   mplier;
   logic               accept, last_iter;

   logic [WIDTH-1:0]   addend, res;
   logic [WIDTH:0]     sum;
   logic               res_co, res_ov, res_err;

   assign IN_READY  = (state == S_IDLE);
   assign OUT_VALID = (state == S_DONE);
   assign accept    = IN_VALID && IN_READY;
   assign last_iter = (state == S_BUSY) && (cnt == CW'(WIDTH - 1));
   // Multiplier is shifted right each iteration, so bit 0 is always bit i.
   assign acc_nxt   = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      addend  = (A == OP_SUB) ? ~In2 : In2;
      sum     = {1'b0, In1} + {1'b0, addend} + {{WIDTH{1'b0}}, CI};
      res     = '0;
      res_co  = 1'b0;
      res_ov  = 1'b0;
      res_err = 1'b0;
      case (A)
         OP_XOR: res = In1 ^ In2;
         OP_AND: res = In1 & In2;
         OP_OR:  res = In1 | In2;
         OP_NOT: res = ~In1;
         OP_ADD, OP_SUB: begin
            res    = sum[WIDTH-1:0];
            res_co = sum[WIDTH];
            res_ov = (In1[WIDTH-1] == addend[WIDTH-1]) &&
                     (sum[WIDTH-1] != In1[WIDTH-1]);
         end
         default: res_err = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = (A == OP_MUL) ? S_BUSY : S_DONE;
         S_BUSY:  if (last_iter) state_nxt = S_DONE;
         S_DONE:  if (OUT_READY) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Cout   <= '0;
         CO     <= 1'b0;
         OV     <= 1'b0;
         ZF     <= 1'b0;
         ERR    <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (accept) begin
         if (A == OP_MUL) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, In1};
            mplier <= In2;
         end else begin
            Cout <= res;
            CO   <= res_co;
            OV   <= res_ov;
            ZF   <= (res == '0);
            ERR  <= res_err;
         end
      end else if (state == S_BUSY) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (last_iter) begin
            Cout <= acc_nxt[WIDTH-1:0];
            CO   <= |acc_nxt[2*WIDTH-1:WIDTH];
            OV   <= 1'b0;
            ZF   <= (acc_nxt[WIDTH-1:0] == '0);
            ERR  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed self-checking bench for alu_seq (WIDTH=32 and WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] In1 = '0, In2 = '0, Cout;
   logic        CI = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
   logic [2:0]  A = '0;
   logic        IN_READY, CO, OV, ZF, ERR, OUT_VALID;

   logic [7:0]  in1_8 = '0, in2_8 = '0, cout_8;
   logic        ci_8 = 1'b0, valid_8 = 1'b0, oready_8 = 1'b0;
   logic [2:0]  a_8 = '0;
   logic        iready_8, co_8, ov_8, zf_8, err_8, ovalid_8;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 CLK = ~CLK;

   alu_seq #(.WIDTH(32)) u_dut (
      .CLK(CLK), .RST(RST), .In1(In1), .In2(In2), .CI(CI), .A(A),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Cout(Cout), .CO(CO),
      .OV(OV), .ZF(ZF), .ERR(ERR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .CLK(CLK), .RST(RST), .In1(in1_8), .In2(in2_8), .CI(ci_8), .A(a_8),
      .IN_VALID(valid_8), .IN_READY(iready_8), .Cout(cout_8), .CO(co_8),
      .OV(ov_8), .ZF(zf_8), .ERR(err_8), .OUT_VALID(ovalid_8), .OUT_READY(oready_8)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request for exactly one edge, then scramble the operands.
   task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic c);
      A = op; In1 = x; In2 = y; CI = c; IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0; In1 = 32'hDEAD_BEEF; In2 = 32'h1234_5678; CI = ~c;
   endtask

   task automatic take(input string tag);
      OUT_READY = 1'b1;
      step();
      OUT_READY = 1'b0;
      chk({tag, "_ovalid_after_take"}, OUT_VALID, 1'b0);
      chk({tag, "_iready_after_take"}, IN_READY, 1'b1);
   endtask

   task automatic chk_res(input string tag, input logic [31:0] r, input logic co_e,
                          input logic ov_e, input logic zf_e, input logic err_e);
      chk({tag, "_ovalid"}, OUT_VALID, 1'b1);
      chk({tag, "_cout"}, Cout, r);
      chk({tag, "_co"}, CO, co_e);
      chk({tag, "_ov"}, OV, ov_e);
      chk({tag, "_zf"}, ZF, zf_e);
      chk({tag, "_err"}, ERR, err_e);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      chk("rst_iready", IN_READY, 1'b1);
      chk("rst_ovalid", OUT_VALID, 1'b0);
      chk("rst_cout", Cout, 32'h0);
      chk("rst_zf", ZF, 1'b0);
      chk("rst_err", ERR, 1'b0);
      IN_VALID = 1'b1;
      step();
      chk("rst_no_accept", OUT_VALID, 1'b0);
      IN_VALID = 1'b0;
      RST = 1'b0;
      step();

      issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      chk_res("add_wrap", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("add_wrap_iready", IN_READY, 1'b0);
      take("add_wrap");

      issue(3'b001, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      chk_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      take("add_ovf");

      issue(3'b101, 32'd5, 32'd7, 1'b1);
      chk_res("sub_5m7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      take("sub_5m7");

      issue(3'b101, 32'd7, 32'd5, 1'b1);
      chk_res("sub_7m5", 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
      take("sub_7m5");

      issue(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
      chk_res("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
      take("and");

      issue(3'b011, 32'h0F0F_0000, 32'h0000_00F0, 1'b1);
      chk_res("or", 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
      take("or");

      issue(3'b100, 32'h0000_0000, 32'h1234_5678, 1'b1);
      chk_res("not", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      take("not");

      // MUL latency: edges from accept until OUT_VALID must equal WIDTH.
      issue(3'b110, 32'd6, 32'd7, 1'b1);
      n = 0;
      while (!OUT_VALID && n < 200) begin step(); n++; end
      chk("mul_6x7_latency", n, 32);
      chk_res("mul_6x7", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
      take("mul_6x7");

      issue(3'b110, 32'h0001_0000, 32'h0001_0000, 1'b0);
      n = 0;
      while (!OUT_VALID && n < 200) begin step(); n++; end
      chk("mul_big_latency", n, 32);
      chk_res("mul_big", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      take("mul_big");

      a_8 = 3'b110; in1_8 = 8'h10; in2_8 = 8'h10; valid_8 = 1'b1;
      step();
      valid_8 = 1'b0; in1_8 = 8'hFF; in2_8 = 8'hFF;
      n = 0;
      while (!ovalid_8 && n < 200) begin step(); n++; end
      chk("mul8_latency", n, 8);
      chk("mul8_cout", cout_8, 8'h00);
      chk("mul8_co", co_8, 1'b1);
      chk("mul8_zf", zf_8, 1'b1);
      oready_8 = 1'b1;
      step();
      oready_8 = 1'b0;
      chk("mul8_take", ovalid_8, 1'b0);

      // Backpressure with a competing request held on the input side.
      issue(3'b000, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0);
      A = 3'b001; In1 = 32'd3; In2 = 32'd4; CI = 1'b0; IN_VALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_cout", Cout, 32'h5A5A_5A5A);
         chk("bp_ovalid", OUT_VALID, 1'b1);
         chk("bp_iready", IN_READY, 1'b0);
         step();
      end
      OUT_READY = 1'b1;
      step();
      OUT_READY = 1'b0;
      chk("bp_idle_iready", IN_READY, 1'b1);
      chk("bp_idle_ovalid", OUT_VALID, 1'b0);
      chk("bp_idle_cout_kept", Cout, 32'h5A5A_5A5A);
      step();
      IN_VALID = 1'b0;
      chk_res("bp_next_add", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      take("bp_next_add");

      issue(3'b111, 32'h1234_5678, 32'h1111_1111, 1'b1);
      chk_res("reserved", 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      take("reserved");

      issue(3'b001, 32'd3, 32'd4, 1'b1);
      chk_res("add_after_err", 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      take("add_after_err");

      // Reset during BUSY cycle 10 must clear outputs without waiting for an edge.
      issue(3'b110, 32'd3, 32'd5, 1'b0);
      for (int i = 0; i < 9; i++) step();
      chk("mid_mul_busy", IN_READY, 1'b0);
      #2 RST = 1'b1;
      #1;
      chk("rst_mid_cout", Cout, 32'h0);
      chk("rst_mid_ovalid", OUT_VALID, 1'b0);
      chk("rst_mid_iready", IN_READY, 1'b1);
      step();
      step();
      RST = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (OUT_VALID) n++;
         step();
      end
      chk("rst_mid_no_result", n, 0);
      chk("rst_mid_idle", IN_READY, 1'b1);
      issue(3'b001, 32'd1, 32'd1, 1'b0);
      chk_res("post_rst_add", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      take("post_rst_add");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
